// File: rtl/focal_max_pool_stream.sv
// focal_max_pool_stream: streaming 2x2 max/min pooling of raster-order pixels.
// One pooled value per 2x2 window, emitted after the window's bottom-right pixel.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode_min            0 = max pool, 1 = min pool (latched on first pixel of frame)
//   in_data/in_valid    pixel stream input, in_ready back-pressure output
//   out_data/out_valid  pooled value output, out_ready from downstream
//   out_last            marks the final pooled value of a frame
//   out_idx             (FOCAL_POOL_ARGIDX_EN only) winner position in window:
//                       0=top-left 1=top-right 2=bottom-left 3=bottom-right
//
// Optional feature macro: FOCAL_POOL_ARGIDX_EN
module focal_max_pool_stream #(
    parameter int DW    = 4,
    parameter int ROW_W = 8,
    parameter int ROW_H = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_min,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last
`ifdef FOCAL_POOL_ARGIDX_EN
    ,
    output logic [1:0]    out_idx
`endif
);

    localparam int CW  = (ROW_W > 2) ? $clog2(ROW_W) : 1;
    localparam int RW  = (ROW_H > 2) ? $clog2(ROW_H) : 1;
    localparam int NLB = ROW_W / 2;
    localparam int LW  = (NLB > 1) ? $clog2(NLB) : 1;
`ifdef FOCAL_POOL_ARGIDX_EN
    localparam int LBW = DW + 1;
`else
    localparam int LBW = DW;
`endif

    typedef enum logic {
        S_FILL = 1'b0,
        S_POOL = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            mode_q;
    logic [DW-1:0]   p0_q;
    logic [DW-1:0]   out_data_q;
    logic            out_valid_q;
    logic            out_last_q;

    logic [LBW-1:0]  linebuf [NLB];

    logic            in_xfer;
    logic            frame_start;
    logic            cur_min;
    logic            col_last;
    logic            row_last;
    logic [LW-1:0]   lb_idx;
    logic            h_pick_r;
    logic [DW-1:0]   h_val;
    logic [LBW-1:0]  lb_rd;
    logic [LBW-1:0]  lb_wr;
    logic [DW-1:0]   top_val;
    logic            v_pick_b;
    logic [DW-1:0]   res;
    logic            lb_we;
    logic            new_res;

`ifdef FOCAL_POOL_ARGIDX_EN
    logic [1:0]      out_idx_q;
    logic [1:0]      res_idx;
`endif

    // Upstream may push whenever the output slot is empty or draining.
    assign in_ready    = ~out_valid_q | out_ready;
    assign in_xfer     = in_valid & in_ready;

    assign frame_start = (col_q == '0) && (row_q == '0);
    // The first pixel of a frame already uses the incoming mode.
    assign cur_min     = frame_start ? mode_min : mode_q;

    assign col_last    = (col_q == CW'(ROW_W - 1));
    assign row_last    = (row_q == RW'(ROW_H - 1));
    assign lb_idx      = LW'(col_q >> 1);

    always_comb begin
        col_d = col_last ? '0 : col_q + CW'(1);
        row_d = row_q;
        if (col_last) begin
            row_d = row_last ? '0 : row_q + RW'(1);
        end
    end

    // Strict compares so that on a tie the earlier pixel (left / top) wins.
    assign h_pick_r = cur_min ? (in_data < p0_q) : (in_data > p0_q);
    assign h_val    = h_pick_r ? in_data : p0_q;

    assign lb_rd    = linebuf[lb_idx];
    assign top_val  = lb_rd[DW-1:0];
    assign v_pick_b = cur_min ? (h_val < top_val) : (h_val > top_val);
    assign res      = v_pick_b ? h_val : top_val;

`ifdef FOCAL_POOL_ARGIDX_EN
    assign lb_wr    = {h_pick_r, h_val};
    assign res_idx  = v_pick_b ? {1'b1, h_pick_r} : {1'b0, lb_rd[DW]};
`else
    assign lb_wr    = h_val;
`endif

    assign lb_we    = in_xfer & col_q[0] & (state_q == S_FILL);
    assign new_res  = in_xfer & col_q[0] & (state_q == S_POOL);

    // Line buffer holds the top-row pair results; every entry is rewritten
    // during the fill row before it is read, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= lb_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= 1'b0;
            p0_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef FOCAL_POOL_ARGIDX_EN
            out_idx_q   <= 2'd0;
`endif
        end else begin
            if (in_xfer) begin
                col_q <= col_d;
                row_q <= row_d;
                if (frame_start) begin
                    mode_q <= mode_min;
                end
                if (!col_q[0]) begin
                    p0_q <= in_data;
                end
                if (col_last) begin
                    unique case (state_q)
                        S_FILL:  state_q <= S_POOL;
                        S_POOL:  state_q <= S_FILL;
                        default: state_q <= S_FILL;
                    endcase
                    if (row_last) begin
                        state_q <= S_FILL;
                    end
                end
            end

            // A new result overrides a simultaneous drain, keeping valid high.
            if (new_res) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res;
                out_last_q  <= col_last & row_last;
`ifdef FOCAL_POOL_ARGIDX_EN
                out_idx_q   <= res_idx;
`endif
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
`ifdef FOCAL_POOL_ARGIDX_EN
    assign out_idx   = out_idx_q;
`endif

endmodule

// File: tb/tb_focal_max_pool_stream.sv
// tb_focal_max_pool_stream: scoreboard bench for focal_max_pool_stream,
// ROW_W=4, ROW_H=2, DW=4, directed frames with hand-computed results.
module tb_focal_max_pool_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_min;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
`ifdef FOCAL_POOL_ARGIDX_EN
    logic [1:0] out_idx;
`endif

    focal_max_pool_stream #(
        .DW    (4),
        .ROW_W (4),
        .ROW_H (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_min  (mode_min),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef FOCAL_POOL_ARGIDX_EN
        ,
        .out_idx   (out_idx)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] d;
        logic       l;
        logic [1:0] ix;
        bit         lat;
        int         vis;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    logic [3:0] px  [8];
    bit         mm  [8];
    logic [3:0] e_d [2];
    logic [1:0] e_i [2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input logic l,
                        input logic [1:0] ix, input bit lat, input int vis);
        exp_t e;
        e.d = d; e.l = l; e.ix = ix; e.lat = lat; e.vis = vis;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_output", q.size(), 1);
            end else begin
                mon_e = q.pop_front();
                chk("out_data", int'(out_data), int'(mon_e.d));
                chk("out_last", int'(out_last), int'(mon_e.l));
`ifdef FOCAL_POOL_ARGIDX_EN
                chk("out_idx", int'(out_idx), int'(mon_e.ix));
`endif
                if (mon_e.lat) chk("latency_cycle", cyc, mon_e.vis);
            end
        end
    end

    // Presents one pixel; returns the cycle in which its result would appear.
    task automatic send(input logic [3:0] d, input bit m, output int vis);
        int t;
        t = 0;
        @(negedge clk);
        in_data  = d;
        mode_min = m;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", int'(in_ready), 1);
        vis = cyc + 1;
    endtask

    task automatic frame(input bit lat);
        int v;
        for (int i = 0; i < 8; i++) begin
            send(px[i], mm[i], v);
            if (i == 5) push(e_d[0], 1'b0, e_i[0], lat, v);
            if (i == 7) push(e_d[1], 1'b1, e_i[1], lat, v);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while (q.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        mode_min  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // 1: max mode
        px  = '{4'd1, 4'd9, 4'd3, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8};
        mm  = '{0, 0, 0, 0, 0, 0, 0, 0};
        e_d = '{4'd9, 4'd8};
        e_i = '{2'd1, 2'd3};
        frame(1'b1);
        drain();

        // 2: min mode latched at first pixel, toggling afterwards ignored
        mm  = '{1, 0, 1, 0, 0, 1, 0, 1};
        e_d = '{4'd1, 4'd2};
        e_i = '{2'd0, 2'd1};
        frame(1'b1);
        drain();

        // 3: ties
        px  = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6};
        mm  = '{0, 0, 0, 0, 0, 0, 0, 0};
        e_d = '{4'd6, 4'd6};
        e_i = '{2'd0, 2'd0};
        frame(1'b1);
        px  = '{4'd2, 4'd7, 4'd0, 4'd0, 4'd7, 4'd7, 4'd0, 4'd0};
        e_d = '{4'd7, 4'd0};
        e_i = '{2'd1, 2'd0};
        frame(1'b1);
        drain();

        // 4: back-pressure holds output and stalls input
        out_ready = 1'b0;
        send(4'd1, 1'b0, v);
        send(4'd9, 1'b0, v);
        send(4'd3, 1'b0, v);
        send(4'd2, 1'b0, v);
        send(4'd4, 1'b0, v);
        send(4'd5, 1'b0, v);
        push(4'd9, 1'b0, 2'd1, 1'b0, v);
        @(negedge clk);
        in_data = 4'd7;
        #1;
        chk("bp_first_valid", int'(out_valid), 1);
        chk("bp_first_data", int'(out_data), 9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_hold_data", int'(out_data), 9);
            chk("bp_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        send(4'd8, 1'b0, v);
        push(4'd8, 1'b1, 2'd3, 1'b1, v);
        drain();

        // 5: three back-to-back frames
        px  = '{4'd4, 4'd15, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
        e_d = '{4'd15, 4'd15};
        e_i = '{2'd1, 2'd1};
        for (int f = 0; f < 3; f++) frame(1'b1);
        drain();

        // 6: mid-frame reset
        send(4'd1, 1'b0, v);
        send(4'd9, 1'b0, v);
        send(4'd3, 1'b0, v);
        send(4'd2, 1'b0, v);
        send(4'd4, 1'b0, v);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        chk("mrst_out_valid", int'(out_valid), 0);
        chk("mrst_out_last", int'(out_last), 0);
        chk("mrst_out_data", int'(out_data), 0);
        rst = 1'b0;
        px  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd0, 4'd0, 4'd1};
        e_d = '{4'd1, 4'd3};
        e_i = '{2'd1, 2'd1};
        frame(1'b1);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
